// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - iterative AES MixColumns, one column per clock
// Shares a single GF(2^8) column multiplier across the four columns of a block.
module mix_columns_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        last_round,
  input  logic [31:0] SR1,
  input  logic [31:0] SR2,
  input  logic [31:0] SR3,
  input  logic [31:0] SR4,
  output logic [31:0] MC1,
  output logic [31:0] MC2,
  output logic [31:0] MC3,
  output logic [31:0] MC4,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, COL} state_t;

  state_t      state;
  logic [1:0]  col;
  logic        byp;
  logic [31:0] in1, in2, in3, in4;
  logic [31:0] w1, w2, w3, w4;
  logic [31:0] w1_nx, w2_nx, w3_nx, w4_nx;
  logic [7:0]  a0, a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Column 0 is the most significant byte of each row word.
  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] c);
    case (c)
      2'd0:    pick = w[31:24];
      2'd1:    pick = w[23:16];
      2'd2:    pick = w[15:8];
      default: pick = w[7:0];
    endcase
  endfunction

  function automatic logic [31:0] place(input logic [31:0] w, input logic [1:0] c,
                                        input logic [7:0] b);
    place = w;
    case (c)
      2'd0:    place[31:24] = b;
      2'd1:    place[23:16] = b;
      2'd2:    place[15:8]  = b;
      default: place[7:0]   = b;
    endcase
  endfunction

  always_comb begin
    a0 = pick(in1, col);
    a1 = pick(in2, col);
    a2 = pick(in3, col);
    a3 = pick(in4, col);
    if (byp) begin
      b0 = a0;
      b1 = a1;
      b2 = a2;
      b3 = a3;
    end else begin
      b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    w1_nx = place(w1, col, b0);
    w2_nx = place(w2, col, b1);
    w3_nx = place(w3, col, b2);
    w4_nx = place(w4, col, b3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      col   <= 2'd0;
      byp   <= 1'b0;
      in1   <= '0;
      in2   <= '0;
      in3   <= '0;
      in4   <= '0;
      w1    <= '0;
      w2    <= '0;
      w3    <= '0;
      w4    <= '0;
      MC1   <= '0;
      MC2   <= '0;
      MC3   <= '0;
      MC4   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            in1   <= SR1;
            in2   <= SR2;
            in3   <= SR3;
            in4   <= SR4;
            byp   <= last_round;
            col   <= 2'd0;
            state <= COL;
            busy  <= 1'b1;
          end
        end
        COL: begin
          w1  <= w1_nx;
          w2  <= w2_nx;
          w3  <= w3_nx;
          w4  <= w4_nx;
          col <= col + 2'd1;
          // Final column: publish including the byte computed on this edge.
          if (col == 2'd3) begin
            MC1   <= w1_nx;
            MC2   <= w2_nx;
            MC3   <= w3_nx;
            MC4   <= w4_nx;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - self-checking bench for mix_columns_seq
// Reference model: matrix product over GF(2^8) on a 4x4 byte state.
module tb_mix_columns_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        last_round = 1'b0;
  logic [31:0] SR1 = '0, SR2 = '0, SR3 = '0, SR4 = '0;
  logic [31:0] MC1, MC2, MC3, MC4;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] FIPS_IN  = 128'hdbf201c6_130a01c6_532201c6_455c01c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6;

  mix_columns_seq dut (
    .clk(clk), .reset(reset), .start(start), .last_round(last_round),
    .SR1(SR1), .SR2(SR2), .SR3(SR3), .SR4(SR4),
    .MC1(MC1), .MC2(MC2), .MC3(MC3), .MC4(MC4),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] x, input int k);
    logic [7:0] p = 8'h00;
    logic [7:0] a = x;
    for (int i = 0; i < 8; i++) begin
      if ((k >> i) & 1) p = p ^ a;
      a = (a << 1) ^ ((a & 8'h80) != 0 ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] rows, input bit bypass);
    int m [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    logic [7:0] s [4][4];
    logic [7:0] o [4][4];
    logic [127:0] r;
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++)
        s[rr][c] = rows[127 - 32*rr - 8*c -: 8];
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++) begin
        o[rr][c] = 8'h00;
        for (int k = 0; k < 4; k++)
          o[rr][c] = o[rr][c] ^ gmul(s[k][c], bypass ? (rr == k ? 1 : 0) : m[rr][k]);
      end
    r = '0;
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++)
        r[127 - 32*rr - 8*c -: 8] = o[rr][c];
    return r;
  endfunction

  // Drives one job from the negedge before E0; returns edges from E0 to done (-1 on timeout).
  task automatic run_job(input logic [127:0] rows, input bit lr,
                         output int lat, output int busy_cnt);
    @(negedge clk);
    {SR1, SR2, SR3, SR4} = rows;
    last_round = lr;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = e;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({MC1, MC2, MC3, MC4, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h %b %b, want 0", {MC1, MC2, MC3, MC4}, busy, done);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_fips;
    int lat, bc;
    run_job(FIPS_IN, 1'b0, lat, bc);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL fips_latency: got %0d, want 4", lat);
    end
    n_cmp++;
    if (bc !== 4) begin
      n_bad++;
      $display("FAIL fips_busy_cycles: got %0d, want 4", bc);
    end
    n_cmp++;
    if ({MC1, MC2, MC3, MC4} !== FIPS_OUT) begin
      n_bad++;
      $display("FAIL fips_result: got %h, want %h", {MC1, MC2, MC3, MC4}, FIPS_OUT);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL fips_busy_at_done: got %b, want 0", busy);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL fips_done_pulse: got %b, want 0", done);
    end
  endtask

  task automatic test_bypass;
    int lat, bc;
    run_job(FIPS_IN, 1'b1, lat, bc);
    n_cmp++;
    if (lat !== 4 || {MC1, MC2, MC3, MC4} !== FIPS_IN) begin
      n_bad++;
      $display("FAIL bypass: lat %0d result %h, want 4 %h", lat, {MC1, MC2, MC3, MC4}, FIPS_IN);
    end
  endtask

  task automatic test_hold_ignore;
    int lat = -1;
    int dones = 0;
    @(negedge clk);
    {SR1, SR2, SR3, SR4} = FIPS_IN;
    last_round = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (done) begin
        dones++;
        if (lat < 0) lat = e;
        n_cmp++;
        if ({MC1, MC2, MC3, MC4} !== FIPS_OUT) begin
          n_bad++;
          $display("FAIL hold_result: got %h, want %h", {MC1, MC2, MC3, MC4}, FIPS_OUT);
        end
      end
      if (e == 2) begin
        {SR1, SR2, SR3, SR4} = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
        start = 1'b1;
      end
    end
    n_cmp++;
    if (lat !== 4 || dones !== 1) begin
      n_bad++;
      $display("FAIL hold_single_done: lat %0d dones %0d, want 4 1", lat, dones);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [127:0] rows2 = 128'h2d2d2d2d_26262626_31313131_4c4c4c4c;
    logic [127:0] exp2  = 128'h4d4d4d4d_7e7e7e7e_bdbdbdbd_f8f8f8f8;
    run_job(FIPS_IN, 1'b0, lat, bc);
    {SR1, SR2, SR3, SR4} = rows2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      n_cmp++;
      if ({MC1, MC2, MC3, MC4} !== FIPS_OUT || done !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_hold e%0d: got %h done %b, want %h 0",
                 e, {MC1, MC2, MC3, MC4}, done, FIPS_OUT);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (done !== 1'b1 || {MC1, MC2, MC3, MC4} !== exp2) begin
      n_bad++;
      $display("FAIL b2b_result: done %b got %h, want 1 %h", done, {MC1, MC2, MC3, MC4}, exp2);
    end
    n_cmp++;
    if (model(rows2, 1'b0) !== exp2) begin
      n_bad++;
      $display("FAIL b2b_model: got %h, want %h", model(rows2, 1'b0), exp2);
    end
  endtask

  task automatic test_async_reset;
    int lat, bc;
    int dones = 0;
    @(negedge clk);
    {SR1, SR2, SR3, SR4} = FIPS_IN;
    last_round = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({MC1, MC2, MC3, MC4, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got %h %b %b, want 0", {MC1, MC2, MC3, MC4}, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    n_cmp++;
    if (dones !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_no_done: dones %0d busy %b, want 0 0", dones, busy);
    end
    run_job(FIPS_IN, 1'b0, lat, bc);
    n_cmp++;
    if (lat !== 4 || {MC1, MC2, MC3, MC4} !== FIPS_OUT) begin
      n_bad++;
      $display("FAIL async_rerun: lat %0d got %h, want 4 %h", lat, {MC1, MC2, MC3, MC4}, FIPS_OUT);
    end
  endtask

  task automatic test_column_placement;
    int lat, bc;
    logic [127:0] exp6 = 128'h0000d500_0000d500_0000d700_0000d600;
    run_job(128'h0000d400_0000d400_0000d400_0000d500, 1'b0, lat, bc);
    n_cmp++;
    if (lat !== 4 || {MC1, MC2, MC3, MC4} !== exp6) begin
      n_bad++;
      $display("FAIL column2: lat %0d got %h, want 4 %h", lat, {MC1, MC2, MC3, MC4}, exp6);
    end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [127:0] rows, exp;
    bit lr;
    for (int t = 0; t < 24; t++) begin
      rows = {$urandom, $urandom, $urandom, $urandom};
      lr = ($urandom_range(0, 3) == 0);
      exp = model(rows, lr);
      run_job(rows, lr, lat, bc);
      n_cmp++;
      if (lat !== 4 || {MC1, MC2, MC3, MC4} !== exp) begin
        n_bad++;
        $display("FAIL random%0d byp=%0b: lat %0d got %h, want 4 %h",
                 t, lr, lat, {MC1, MC2, MC3, MC4}, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    n_cmp++;
    if (model(FIPS_IN, 1'b0) !== FIPS_OUT) begin
      n_bad++;
      $display("FAIL model_fips: got %h, want %h", model(FIPS_IN, 1'b0), FIPS_OUT);
    end
    test_fips;
    test_bypass;
    test_hold_ignore;
    test_back_to_back;
    test_async_reset;
    test_column_placement;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
